alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Issue/writeback stage directly upstream of the 16-bit combinational ALU. It accepts one instruction word per transaction over a valid/ready handshake and reads two operands from an internal register file. It drives the ALU operand and op inputs, captures the ALU result and writes it back to the destination register. A side port preloads registers, and a debug port reads them.

Parameters:
DATA_W, 16, datapath width; matches ALU operand and result width
NUM_REGS, 8, register file depth
ADDR_W, 3, register address width; equals log2(NUM_REGS)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present on instr
instr  input  16  [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] ignored
in_ready  output  1  stage can accept instr this cycle
ld_valid  input  1  direct register load request
ld_addr  input  ADDR_W  load destination
ld_data  input  DATA_W  load value
alu_a  output  DATA_W  to ALU input_a
alu_b  output  DATA_W  to ALU input_b
alu_op  output  4  to ALU op
alu_result  input  DATA_W  from ALU out
done  output  1  one-cycle pulse: instruction retired
result  output  DATA_W  value retired with done
illegal  output  1  one-cycle pulse, with done, when op > 4
dbg_addr  input  ADDR_W  debug read address
dbg_data  output  DATA_W  combinational read of R[dbg_addr]

Behaviour:
- Ops: 0 add, 1 sub, 2 and, 3 or, 4 even-parity. 5..15 are illegal.
- R0 always reads 0. Writes to R0 (load or writeback) are discarded.
- FSM states:
  - IDLE: in_ready = !ld_valid.
    - ld_valid=1: R[ld_addr] <= ld_data. Load has priority; no instruction is accepted that cycle.
    - Otherwise, instr_valid && in_ready: latch op/rd/rs/rt, go to EXEC.
  - EXEC: in_ready=0.
    - Drive alu_a=R[rs], alu_b=R[rt], alu_op=op.
    - At the clock edge, capture alu_result into the result register; go to WB.
    - If op is illegal: capture nothing, set the illegal flag.
  - WB: in_ready=0. done=1. result=captured value.
    - Legal op: write R[rd] at the end of this cycle.
    - Illegal op: illegal=1, result=0, no write. Go to IDLE.
- Latency: handshake at edge N, then EXEC in cycle N+1 and done in cycle N+2. Next accept is no earlier than the edge ending cycle N+3. Throughput is one instruction per 3 cycles.
- ld_valid outside IDLE is ignored (dropped). The loader must wait for in_ready or IDLE.
- Operands are read in EXEC, so a preceding WB write to the same register is visible (no hazard).
- alu_a/alu_b/alu_op are registered. They change only on entry to EXEC and hold their values otherwise.
- Arithmetic wraps modulo 2^16 inside the ALU. This stage does no width extension.
- dbg_data is combinational. It shows a WB write from the cycle after the write edge.
- Reset, any time:
  - state=IDLE; all registers, alu_a, alu_b, alu_op, result = 0; done=0; illegal=0.
  - An in-flight instruction is aborted: no writeback, no done.
  - in_ready=0 while reset is high.

Test Plan:
1. Load R1=0x0005, R2=0x0003; issue add rd=3 rs=1 rt=2 -> done at accept+2, result=0x0008, dbg R3=0x0008.
2. Load R1=0x0000, R2=0x0001; sub rd=4 rs=1 rt=2 -> result=0xFFFF. Then add R4+R2 into R5 -> 0x0000 (wrap).
3. Load R1=0x0007; epar rd=6 rs=1 -> result=0x0001. R1=0x0003 -> result=0x0000.
4. Illegal op 0x9 with rd=3 -> done=1, illegal=1, result=0, R3 unchanged. Next legal instruction accepted normally.
5. ld_valid and instr_valid both high in IDLE -> load performed, in_ready=0, instr accepted the following cycle. add with rd=0 -> R0 reads 0.
6. Assert reset during EXEC of and rd=2 -> no done, R2=0, alu_* = 0, in_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of a 16-bit combinational ALU: accepts one
// instruction per handshake, reads operands from a small register file, retires the result.
module alu_issue_stage #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              in_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              illegal,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [NUM_REGS-1:0] we_vec;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_reg;
  logic [DATA_W-1:0]   alu_a_reg, alu_b_reg, result_reg;
  logic [3:0]          alu_op_reg;
  logic                illegal_reg;
  logic                accept, load_en, wb_en, op_illegal;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^instr[2:0];
  assign op_illegal        = (alu_op_reg > 4'd4);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    load_en    = 1'b0;
    wb_en      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !ld_valid && !reset;
        load_en  = ld_valid;
        if (instr_valid && in_ready) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = WB;
      WB: begin
        done       = 1'b1;
        wb_en      = !illegal_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Loads only happen in IDLE and writeback only in WB, so one write port suffices.
  assign wr_data = load_en ? ld_data : result_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
      if (gi == 0) begin : g_r0
        assign we_vec[gi] = 1'b0;
      end else begin : g_rn
        assign we_vec[gi] = (load_en && ld_addr == ADDR_W'(gi)) ||
                            (wb_en && rd_reg == ADDR_W'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_vec[i]) rf[i] <= wr_data;
      end
    end
  end

  // Operands are sampled on the accept edge; nothing can write the file during EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_reg      <= '0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_op_reg  <= '0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        rd_reg     <= instr[11:9];
        alu_a_reg  <= rf[instr[8:6]];
        alu_b_reg  <= rf[instr[5:3]];
        alu_op_reg <= instr[15:12];
      end
      if (state_reg == EXEC) begin
        illegal_reg <= op_illegal;
        result_reg  <= op_illegal ? '0 : alu_result;
      end
    end
  end

  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_op   = alu_op_reg;
  assign result   = result_reg;
  assign illegal  = done && illegal_reg;
  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reference register-file model with a per-cycle
// compare process, plus hand-computed literal checks for each scenario.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        in_ready;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] alu_a, alu_b, alu_result, result, dbg_data;
  logic [3:0]  alu_op;
  logic        done, illegal;
  logic [2:0]  dbg_addr = '0;

  int total = 0;
  int bad   = 0;

  alu_issue_stage #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .in_ready(in_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .done(done), .result(result), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return {15'b0, ^a};
      default: return 16'hDEAD;
    endcase
  endfunction

  // The ALU sitting downstream; illegal ops return junk so a wrong capture is visible.
  always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

  // Reference model: register file plus the in-flight instruction and cycles left.
  logic [15:0] mreg [8];
  int          cnt = 0;
  logic [15:0] m_a = '0, m_b = '0, p_res = '0;
  logic [3:0]  m_op = '0;
  logic [2:0]  p_rd = '0;
  logic        p_ill = 1'b0;

  initial for (int i = 0; i < 8; i++) mreg[i] = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      cnt = 0; m_a = '0; m_b = '0; m_op = '0;
    end else if (cnt == 0) begin
      if (ld_valid) begin
        if (ld_addr != 3'd0) mreg[ld_addr] = ld_data;
      end else if (instr_valid) begin
        m_op  = instr[15:12];
        p_rd  = instr[11:9];
        m_a   = mreg[instr[8:6]];
        m_b   = mreg[instr[5:3]];
        p_ill = (m_op > 4'd4);
        p_res = p_ill ? 16'h0000 : ref_alu(m_op, m_a, m_b);
        cnt   = 2;
      end
    end else if (cnt == 2) begin
      cnt = 1;
    end else begin
      if (!p_ill && p_rd != 3'd0) mreg[p_rd] = p_res;
      cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, !reset && cnt == 0 && !ld_valid});
    chk("cyc_done", {31'b0, done}, {31'b0, cnt == 1});
    chk("cyc_illegal", {31'b0, illegal}, {31'b0, cnt == 1 && p_ill});
    if (cnt == 1) chk("cyc_result", {16'b0, result}, {16'b0, p_res});
    chk("cyc_alu_a", {16'b0, alu_a}, {16'b0, m_a});
    chk("cyc_alu_b", {16'b0, alu_b}, {16'b0, m_b});
    chk("cyc_alu_op", {28'b0, alu_op}, {28'b0, m_op});
    chk("cyc_dbg", {16'b0, dbg_data}, {16'b0, mreg[dbg_addr]});
  end

  task automatic step;
    @(negedge clock);
    #2;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    step;
    ld_valid = 1'b0;
    $display("load R%0d <= %h", a, d);
  endtask

  task automatic dbg_chk(input string nm, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(nm, {16'b0, dbg_data}, {16'b0, exp});
  endtask

  // Issue one instruction from IDLE and check retire timing and value; ends in IDLE.
  task automatic issue(input string nm, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic [15:0] exp_res, input logic exp_ill, output int waits);
    instr = {op, rd, rs, rt, 3'b000};
    instr_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 10) begin
      step;
      waits++;
    end
    chk({nm, "_accept"}, {31'b0, in_ready}, 32'd1);
    step;
    instr_valid = 1'b0;
    chk({nm, "_exec_nodone"}, {31'b0, done}, 32'd0);
    step;
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    chk({nm, "_result"}, {16'b0, result}, {16'b0, exp_res});
    chk({nm, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    $display("txn %s op=%0d rd=%0d rs=%0d rt=%0d result=%h illegal=%0d",
             nm, op, rd, rs, rt, result, illegal);
    step;
    chk({nm, "_idle_nodone"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #1 reset = 1'b1;
    step;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_alu_a", {16'b0, alu_a}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    reset = 1'b0;
    step;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: simple add
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    issue("t1_add", 4'd0, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b0, w);
    dbg_chk("t1_dbg_r3", 3'd3, 16'h0008);

    // 2: subtract underflow, then add wraps to zero
    load(3'd1, 16'h0000);
    load(3'd2, 16'h0001);
    issue("t2_sub", 4'd1, 3'd4, 3'd1, 3'd2, 16'hFFFF, 1'b0, w);
    issue("t2_add_wrap", 4'd0, 3'd5, 3'd4, 3'd2, 16'h0000, 1'b0, w);
    dbg_chk("t2_dbg_r4", 3'd4, 16'hFFFF);

    // 3: even parity
    load(3'd1, 16'h0007);
    issue("t3_epar_odd", 4'd4, 3'd6, 3'd1, 3'd0, 16'h0001, 1'b0, w);
    load(3'd1, 16'h0003);
    issue("t3_epar_even", 4'd4, 3'd6, 3'd1, 3'd0, 16'h0000, 1'b0, w);
    dbg_chk("t3_dbg_r6", 3'd6, 16'h0000);

    // 4: illegal op leaves R3 alone, next instruction is normal
    issue("t4_illegal", 4'd9, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b1, w);
    dbg_chk("t4_dbg_r3", 3'd3, 16'h0008);
    issue("t4_or", 4'd3, 3'd7, 3'd1, 3'd2, 16'h0003, 1'b0, w);
    dbg_chk("t4_dbg_r7", 3'd7, 16'h0003);

    // 5: load beats instruction in the same cycle; R0 stays zero
    ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 16'h00F0;
    instr = {4'd0, 3'd0, 3'd1, 3'd2, 3'b000};
    instr_valid = 1'b1;
    #1;
    chk("t5_in_ready_blocked", {31'b0, in_ready}, 32'd0);
    step;
    ld_valid = 1'b0;
    issue("t5_add_r0", 4'd0, 3'd0, 3'd1, 3'd2, 16'h00F1, 1'b0, w);
    chk("t5_accept_next_cycle", w, 32'd0);
    dbg_chk("t5_dbg_r0", 3'd0, 16'h0000);
    load(3'd0, 16'hFFFF);
    dbg_chk("t5_dbg_r0_load", 3'd0, 16'h0000);

    // 6: reset during EXEC aborts the instruction
    load(3'd2, 16'h1234);
    instr = {4'd2, 3'd2, 3'd1, 3'd2, 3'b000};
    instr_valid = 1'b1;
    #1;
    chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
    step;
    instr_valid = 1'b0;
    chk("t6_alu_op", {28'b0, alu_op}, 32'd2);
    chk("t6_alu_b", {16'b0, alu_b}, 32'h1234);
    reset = 1'b1;
    #1;
    chk("t6_alu_a_rst", {16'b0, alu_a}, 32'd0);
    chk("t6_alu_op_rst", {28'b0, alu_op}, 32'd0);
    chk("t6_in_ready_rst", {31'b0, in_ready}, 32'd0);
    step;
    chk("t6_no_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    step;
    chk("t6_no_done_after", {31'b0, done}, 32'd0);
    chk("t6_in_ready_after", {31'b0, in_ready}, 32'd1);
    dbg_chk("t6_dbg_r2", 3'd2, 16'h0000);
    $display("txn t6_reset_abort rd=2 done=%0d in_ready=%0d", done, in_ready);

    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
